piso: RTL and testbench
=======================

Name: piso

Overview:
- Parallel-in/serial-out converter.
- Accepts WIDTH-bit words over a valid/ready handshake and buffers them in an internal FIFO.
- Shifts each word out one bit at a time over a serial valid/ready handshake.
- Sits between a parallel producer and a bit-serial link; producer and link share one clock domain.

Parameters:
- WIDTH, 8: parallel word width and number of serial bits per word.
- DEPTH, 8: internal FIFO depth in words; power of two, at least 2.
- S_FIFO_EMPTY, 3'b001: one-hot state encoding, idle/waiting for data.
- S_RD_FIFO, 3'b010: one-hot state encoding, pop word into shift register.
- S_DRIVE_SERIAL_INTERFCE, 3'b100: one-hot state encoding, shifting bits out.

Ports:
- pclk_i  input  1  single clock; all logic on rising edge.
- rst_i  input  1  synchronous, active-high reset.
- data_i  input  WIDTH  parallel word from producer.
- valid_i  input  1  producer asserts data_i valid.
- ready_o  output  1  block can accept a word this cycle.
- data_o  output  1  serial data bit.
- valid_o  output  1  data_o carries a valid bit.
- ready_i  input  1  serial sink accepts current bit.

Behaviour:
- Clocking/reset: one clock, pclk_i; reset is synchronous and active-high on rst_i. With rst_i sampled high at an edge:
  - FIFO pointers and count cleared; contents discarded.
  - State forced to S_FIFO_EMPTY; shift register and bit counter cleared.
  - valid_o=0, data_o=0.
- Reset mid-word drops the in-flight word and all buffered words.
- ready_o:
  - Combinational: ready_o = !rst_i && (count < DEPTH).
  - Low during reset; high the cycle after reset deasserts.
- Push: at an edge where valid_i && ready_o, data_i is written at the write pointer and count increments. valid_i while ready_o=0 is ignored; data_i is not captured.
- Simultaneous push and pop in one edge: count unchanged; both pointers advance; pointers wrap modulo DEPTH.
- FSM, one-hot, registered:
  - S_FIFO_EMPTY: valid_o=0, data_o=0. If count>0, go to S_RD_FIFO; else stay.
  - S_RD_FIFO: pop the FIFO head into the shift register, clear bit counter, go to S_DRIVE_SERIAL_INTERFCE. valid_o stays 0 this cycle.
  - S_DRIVE_SERIAL_INTERFCE:
    - valid_o=1; data_o = shift register bit 0 (LSB first).
    - On an edge with valid_o && ready_i: shift register shifts right by 1, bit counter increments.
    - When the accepted bit is bit WIDTH-1: go to S_RD_FIFO if count>0 (after any same-edge push), else S_FIFO_EMPTY.
    - With ready_i=0: hold data_o and valid_o stable.
- valid_o and data_o are registered outputs. data_o=0 whenever valid_o=0.
- Latency: word pushed at edge N with FIFO previously empty:
  - Edge N+1: state S_RD_FIFO.
  - Edge N+2: S_DRIVE_SERIAL_INTERFCE with bit 0 on data_o, valid_o=1.
- Throughput with ready_i held high: WIDTH bit cycles plus one S_RD_FIFO bubble per word.
- Invalid state encodings recover to S_FIFO_EMPTY.
- Full FIFO: ready_o=0 until a pop frees a slot. A pop edge makes ready_o high the following cycle.
- No X on any output after the first reset edge.

Test Plan:
- Reset check: rst_i high for 2 edges -> valid_o=0, data_o=0, ready_o=0 during reset. ready_o=1 after deassert.
- Single word: push 8'hA5 with ready_i tied to valid_o -> valid_o high 2 edges after push. data_o sequence 1,0,1,0,0,1,0,1 for 8 cycles, then valid_o=0.
- Back-to-back words 8'h01, 8'h80, 8'hFF: serial stream is LSB-first per word, with exactly one valid_o=0 cycle between words.
- Backpressure: ready_i=0 for 5 cycles mid-word -> data_o/valid_o frozen, no bit lost or duplicated.
- Full: ready_i=0, push DEPTH+2 words with valid_i held -> ready_o drops after 8 pushes; the extra words are not stored. Release ready_i -> exactly 8 words emerge in order.
- Reset mid-shift at bit 3 of a word with 3 words queued -> valid_o=0 next cycle, FIFO empty, ready_o=1 after reset.

Source files
------------

// File: rtl/piso.sv
// piso: buffers WIDTH-bit words in a FIFO and shifts each out LSB first over a serial valid/ready link.
// Latency: a word pushed into an empty FIFO at edge N has bit 0 on data_o after edge N+2; one idle cycle between words.
// Backpressure: ready_o drops while the FIFO is full; ready_i=0 freezes data_o/valid_o with no bit lost or repeated.

module piso_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_dat,
    output logic [AW:0]      count
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    assign rd_dat = mem[rd_ptr];

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= wr_dat;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

module piso #(
    parameter int         WIDTH                   = 8,
    parameter int         DEPTH                   = 8,
    parameter logic [2:0] S_FIFO_EMPTY            = 3'b001,
    parameter logic [2:0] S_RD_FIFO               = 3'b010,
    parameter logic [2:0] S_DRIVE_SERIAL_INTERFCE = 3'b100
) (
    input  logic             pclk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             valid_i,
    output logic             ready_o,
    output logic             data_o,
    output logic             valid_o,
    input  logic             ready_i
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [2:0] {
        ST_EMPTY = S_FIFO_EMPTY,
        ST_RD    = S_RD_FIFO,
        ST_DRIVE = S_DRIVE_SERIAL_INTERFCE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic [CW-1:0]    bit_cnt;
    logic [WIDTH-1:0] fifo_rd_dat;
    logic [AW:0]      fifo_count;
    logic             fifo_empty;
    logic             push;
    logic             pop;
    logic             last_bit;

    assign ready_o    = !rst_i && (fifo_count < (AW+1)'(DEPTH));
    assign push       = valid_i && ready_o;
    assign fifo_empty = (fifo_count == '0);
    assign pop        = (state == ST_RD) && !fifo_empty;
    assign last_bit   = (bit_cnt == CW'(WIDTH - 1));

    piso_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo (
        .clk    (pclk_i),
        .rst    (rst_i),
        .push   (push),
        .wr_dat (data_i),
        .pop    (pop),
        .rd_dat (fifo_rd_dat),
        .count  (fifo_count)
    );

    always_ff @(posedge pclk_i) begin
        if (rst_i) begin
            state   <= ST_EMPTY;
            shreg   <= '0;
            bit_cnt <= '0;
            valid_o <= 1'b0;
            data_o  <= 1'b0;
        end else begin
            case (state)
                ST_EMPTY: begin
                    valid_o <= 1'b0;
                    data_o  <= 1'b0;
                    if (!fifo_empty) begin
                        state <= ST_RD;
                    end
                end
                ST_RD: begin
                    if (fifo_empty) begin
                        state <= ST_EMPTY;
                    end else begin
                        shreg   <= fifo_rd_dat;
                        bit_cnt <= '0;
                        valid_o <= 1'b1;
                        data_o  <= fifo_rd_dat[0];
                        state   <= ST_DRIVE;
                    end
                end
                ST_DRIVE: begin
                    if (ready_i) begin
                        shreg   <= shreg >> 1;
                        bit_cnt <= bit_cnt + 1'b1;
                        if (last_bit) begin
                            valid_o <= 1'b0;
                            data_o  <= 1'b0;
                            // A push landing on this same edge still counts as queued work.
                            state   <= (!fifo_empty || push) ? ST_RD : ST_EMPTY;
                        end else begin
                            data_o <= shreg[1];
                        end
                    end
                end
                default: begin
                    state   <= ST_EMPTY;
                    valid_o <= 1'b0;
                    data_o  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_piso.sv
// Directed bench for piso: reset, single word, back-to-back words, backpressure, full FIFO, reset mid-word.
`timescale 1ns/1ps

module tb_piso;
    localparam int WIDTH = 8;
    localparam int DEPTH = 8;

    logic             pclk_i = 1'b0;
    logic             rst_i;
    logic [WIDTH-1:0] data_i;
    logic             valid_i;
    logic             ready_o;
    logic             data_o;
    logic             valid_o;
    logic             ready_i;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    piso #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .pclk_i  (pclk_i),
        .rst_i   (rst_i),
        .data_i  (data_i),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .data_o  (data_o),
        .valid_o (valid_o),
        .ready_i (ready_i)
    );

    always #5 pclk_i = ~pclk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge pclk_i);
        #1;
    endtask

    task automatic push_word(input logic [WIDTH-1:0] w);
        data_i  = w;
        valid_i = 1'b1;
        tick();
        valid_i = 1'b0;
    endtask

    task automatic expect_word(input logic [WIDTH-1:0] w, input int budget, input string tag);
        int n = 0;
        while (valid_o !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        check({tag, "_start"}, valid_o, 1);
        for (int i = 0; i < WIDTH; i++) begin
            check($sformatf("%s_bit%0d", tag, i), {valid_o, data_o}, {1'b1, w[i]});
            tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [WIDTH-1:0] w;
        logic [WIDTH-1:0] held;
        int accepted;
        int n;

        rst_i   = 1'b1;
        valid_i = 1'b0;
        data_i  = '0;
        ready_i = 1'b1;

        tick();
        check("rst_e1", {valid_o, data_o, ready_o}, 3'b000);
        tick();
        check("rst_e2", {valid_o, data_o, ready_o}, 3'b000);
        rst_i = 1'b0;
        #1;
        check("rst_release_ready", ready_o, 1);

        w = 8'hA5;
        push_word(w);
        check("a5_lat_push", valid_o, 0);
        tick();
        check("a5_lat_rd", valid_o, 0);
        tick();
        check("a5_lat_drive", {valid_o, data_o}, 2'b11);
        expect_word(w, 0, "a5");
        check("a5_done", {valid_o, data_o}, 2'b00);
        tick(); tick();

        push_word(8'h01);
        push_word(8'h80);
        push_word(8'hFF);
        expect_word(8'h01, 3, "w01");
        check("gap_01_80", valid_o, 0);
        tick();
        expect_word(8'h80, 0, "w80");
        check("gap_80_ff", valid_o, 0);
        tick();
        expect_word(8'hFF, 0, "wff");
        check("bb_done", valid_o, 0);
        tick(); tick();

        w = 8'h6C;
        push_word(w);
        n = 0;
        while (valid_o !== 1'b1 && n < 4) begin
            tick();
            n++;
        end
        check("bp_start", valid_o, 1);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("bp_bit%0d", i), {valid_o, data_o}, {1'b1, w[i]});
            tick();
        end
        ready_i = 1'b0;
        for (int c = 0; c < 5; c++) begin
            check($sformatf("bp_hold%0d", c), {valid_o, data_o}, {1'b1, w[3]});
            tick();
        end
        ready_i = 1'b1;
        for (int i = 3; i < WIDTH; i++) begin
            check($sformatf("bp_bit%0d", i), {valid_o, data_o}, {1'b1, w[i]});
            tick();
        end
        check("bp_done", valid_o, 0);
        tick(); tick();

        ready_i = 1'b0;
        held = 8'hC3;
        push_word(held);
        n = 0;
        while (valid_o !== 1'b1 && n < 4) begin
            tick();
            n++;
        end
        check("full_held_drive", {valid_o, data_o}, {1'b1, held[0]});
        accepted = 0;
        for (int k = 0; k < DEPTH + 2; k++) begin
            data_i  = WIDTH'(8'h10 + k);
            valid_i = 1'b1;
            #0;
            if (ready_o) accepted++;
            tick();
        end
        valid_i = 1'b0;
        check("full_accepted", accepted, DEPTH);
        check("full_ready_low", ready_o, 0);
        ready_i = 1'b1;
        expect_word(held, 0, "full_held");
        for (int k = 0; k < DEPTH; k++) begin
            check($sformatf("full_gap%0d", k), valid_o, 0);
            tick();
            expect_word(WIDTH'(8'h10 + k), 0, $sformatf("full_w%0d", k));
        end
        check("full_done", valid_o, 0);
        tick(); tick();

        ready_i = 1'b0;
        w = 8'h5A;
        push_word(w);
        push_word(8'h11);
        push_word(8'h22);
        push_word(8'h33);
        n = 0;
        while (valid_o !== 1'b1 && n < 4) begin
            tick();
            n++;
        end
        ready_i = 1'b1;
        tick(); tick(); tick();
        check("mrst_bit3", {valid_o, data_o}, {1'b1, w[3]});
        rst_i = 1'b1;
        tick();
        check("mrst_out", {valid_o, data_o, ready_o}, 3'b000);
        rst_i = 1'b0;
        #1;
        check("mrst_ready", ready_o, 1);
        tick(); tick(); tick();
        check("mrst_empty", {valid_o, data_o}, 2'b00);

        if (n_fail == 0) $display("TEST PASSED");
        else             $display("TEST FAILED");
        $display("SUMMARY: %0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
